// File: rtl/metro_gate_ctrl.sv
// metro_gate_ctrl: access-gate controller.
// A presented access code is captured in IDLE, range-checked for one cycle, and
// then either opens the door for a bounded window (ACCESS_GRANTED), rejects it
// for one cycle (DENIED), or locks the gate out for a fixed time after
// MAX_FAILS consecutive rejects (LOCKOUT).
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-low reset
//   access_code      in   presented code (sampled only in IDLE)
//   validate_code    in   request to check access_code (honoured only in IDLE)
//   pass_sensor      in   passenger cleared the gate (honoured only in ACCESS_GRANTED)
//   open_access_door out  door release, high in every ACCESS_GRANTED cycle
//   state_out        out  present state encoding
//   code_accepted    out  pulse in the first ACCESS_GRANTED cycle
//   code_rejected    out  pulse in the DENIED cycle or first LOCKOUT cycle
//   lockout          out  high throughout LOCKOUT
//   fail_count       out  consecutive rejects
//   pass_count       out  completed passages, wraps at 16 bits
//
// Legal parameters: CODE_MIN <= CODE_MAX <= 2^CODE_W-1,
// OPEN_CYCLES and LOCK_CYCLES in 1..2^CNT_W, MAX_FAILS >= 1.
module metro_gate_ctrl #(
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned CODE_MIN    = 4,
    parameter int unsigned CODE_MAX    = 11,
    parameter int unsigned OPEN_CYCLES = 16,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 64,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned FAIL_W     = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] access_code,
    input  logic              validate_code,
    input  logic              pass_sensor,
    output logic              open_access_door,
    output logic [2:0]        state_out,
    output logic              code_accepted,
    output logic              code_rejected,
    output logic              lockout,
    output logic [FAIL_W-1:0] fail_count,
    output logic [15:0]       pass_count
);

    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StCheck   = 3'b001,
        StGrant   = 3'b010,
        StDenied  = 3'b011,
        StLockout = 3'b100
    } state_e;

    localparam logic [CODE_W-1:0] CodeLo   = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0] CodeHi   = CODE_W'(CODE_MAX);
    localparam logic [CNT_W-1:0]  OpenLast = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LockLast = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FailMax  = FAIL_W'(MAX_FAILS);

    state_e              state;
    logic [CNT_W-1:0]    timer;
    logic [CODE_W-1:0]   code_q;
    logic                code_ok;
    logic [FAIL_W-1:0]   fail_inc;

    assign state_out = state;
    assign code_ok   = (code_q >= CodeLo) && (code_q <= CodeHi);
    assign fail_inc  = fail_count + FAIL_W'(1);

    // Outputs are assigned on the transition into each state so that they are
    // registered yet always agree with state_out in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= StIdle;
            timer            <= '0;
            code_q           <= '0;
            fail_count       <= '0;
            pass_count       <= '0;
            open_access_door <= 1'b0;
            code_accepted    <= 1'b0;
            code_rejected    <= 1'b0;
            lockout          <= 1'b0;
        end else begin
            code_accepted <= 1'b0;
            code_rejected <= 1'b0;
            case (state)
                StIdle: begin
                    timer            <= '0;
                    open_access_door <= 1'b0;
                    lockout          <= 1'b0;
                    if (validate_code) begin
                        code_q <= access_code;
                        state  <= StCheck;
                    end
                end
                StCheck: begin
                    timer <= '0;
                    if (code_ok) begin
                        state            <= StGrant;
                        fail_count       <= '0;
                        code_accepted    <= 1'b1;
                        open_access_door <= 1'b1;
                    end else begin
                        fail_count    <= fail_inc;
                        code_rejected <= 1'b1;
                        if (fail_inc == FailMax) begin
                            state   <= StLockout;
                            lockout <= 1'b1;
                        end else begin
                            state <= StDenied;
                        end
                    end
                end
                StGrant: begin
                    // A passage on the final open cycle still counts.
                    if (pass_sensor || (timer == OpenLast)) begin
                        state            <= StIdle;
                        timer            <= '0;
                        open_access_door <= 1'b0;
                        if (pass_sensor) begin
                            pass_count <= pass_count + 16'd1;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                StDenied: begin
                    timer <= '0;
                    state <= StIdle;
                end
                StLockout: begin
                    if (timer == LockLast) begin
                        state      <= StIdle;
                        timer      <= '0;
                        lockout    <= 1'b0;
                        fail_count <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: begin
                    state            <= StIdle;
                    timer            <= '0;
                    open_access_door <= 1'b0;
                    lockout          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_metro_gate_ctrl.sv
// tb_metro_gate_ctrl: directed stimulus for metro_gate_ctrl with a behavioural
// model (state + age-in-state) checked every cycle, plus literal expectations.
module tb_metro_gate_ctrl;

    localparam int unsigned CODE_MIN = 4;
    localparam int unsigned CODE_MAX = 11;
    localparam int unsigned OPEN     = 16;
    localparam int unsigned MAXF     = 3;
    localparam int unsigned LOCK     = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  access_code = '0;
    logic        validate_code = 1'b0;
    logic        pass_sensor = 1'b0;
    logic        open_access_door;
    logic [2:0]  state_out;
    logic        code_accepted;
    logic        code_rejected;
    logic        lockout;
    logic [1:0]  fail_count;
    logic [15:0] pass_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic        preload_req = 1'b0;
    logic [15:0] preload_val = '0;

    metro_gate_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .access_code      (access_code),
        .validate_code    (validate_code),
        .pass_sensor      (pass_sensor),
        .open_access_door (open_access_door),
        .state_out        (state_out),
        .code_accepted    (code_accepted),
        .code_rejected    (code_rejected),
        .lockout          (lockout),
        .fail_count       (fail_count),
        .pass_count       (pass_count)
    );

    always #5 clk = ~clk;

    // Model: st 0 idle, 1 checking, 2 door open, 3 denied, 4 locked out;
    // age counts cycles spent in the current state.
    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  age;
        logic [1:0]  fail;
        logic [15:0] pass;
        logic [3:0]  code;
    } model_t;

    model_t m;

    function automatic model_t step(model_t c, logic v, logic [3:0] code, logic ps,
                                    logic pre, logic [15:0] pv);
        model_t n;
        n = c;
        if (pre) n.pass = pv;
        case (c.st)
            3'd0: if (v) begin n.code = code; n.st = 3'd1; n.age = 0; end
            3'd1: begin
                n.age = 0;
                if (c.code >= CODE_MIN && c.code <= CODE_MAX) begin
                    n.fail = 0;
                    n.st   = 3'd2;
                end else begin
                    n.fail = c.fail + 2'd1;
                    n.st   = (n.fail == MAXF) ? 3'd4 : 3'd3;
                end
            end
            3'd2: begin
                if (ps) begin
                    n.pass = n.pass + 16'd1;
                    n.st   = 3'd0;
                    n.age  = 0;
                end else if (c.age + 1 == OPEN) begin
                    n.st  = 3'd0;
                    n.age = 0;
                end else begin
                    n.age = c.age + 8'd1;
                end
            end
            3'd3: begin n.st = 3'd0; n.age = 0; end
            3'd4: begin
                if (c.age + 1 == LOCK) begin
                    n.st   = 3'd0;
                    n.age  = 0;
                    n.fail = 0;
                end else begin
                    n.age = c.age + 8'd1;
                end
            end
            default: n.st = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [24:0] exp_vec(model_t x);
        return {x.st,
                x.st == 3'd2,
                x.st == 3'd2 && x.age == 0,
                x.st == 3'd3 || (x.st == 3'd4 && x.age == 0),
                x.st == 3'd4,
                x.fail,
                x.pass};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else m <= step(m, validate_code, access_code, pass_sensor, preload_req, preload_val);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("cycle {state,door,acc,rej,lock,fail,pass}",
                  32'({state_out, open_access_door, code_accepted, code_rejected, lockout,
                       fail_count, pass_count}),
                  32'(exp_vec(m)));
        end
    end

    task automatic present(input logic [3:0] c);
        @(negedge clk);
        access_code   = c;
        validate_code = 1'b1;
        @(negedge clk);
        validate_code = 1'b0;
        access_code   = 4'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && state_out != 3'd0; i++) @(negedge clk);
        check("return to idle", 32'(state_out), 32'd0);
    endtask

    task automatic do_pass(input logic [3:0] c);
        present(c);
        @(negedge clk);
        pass_sensor = 1'b1;
        @(negedge clk);
        pass_sensor = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset state", 32'(state_out), 32'd0);
        check("reset door", 32'(open_access_door), 32'd0);
        check("reset pass_count", 32'(pass_count), 32'd0);
        check("reset lockout", 32'(lockout), 32'd0);
        rst = 1'b1;

        // Grant and timeout
        present(4'd7);
        check("grant: check state", 32'(state_out), 32'd1);
        @(negedge clk);
        check("grant: granted state", 32'(state_out), 32'd2);
        check("grant: accept pulse", 32'(code_accepted), 32'd1);
        n = 1;
        repeat (30) begin
            @(negedge clk);
            if (open_access_door) n++;
        end
        check("grant: door cycles", 32'(n), 32'd16);
        check("grant: back to idle", 32'(state_out), 32'd0);
        check("grant: no passage", 32'(pass_count), 32'd0);

        // Early passage in 5th cycle, then passage on the 16th cycle
        present(4'd4);
        repeat (5) @(negedge clk);
        check("early: door open cycle 5", 32'(open_access_door), 32'd1);
        pass_sensor = 1'b1;
        @(negedge clk);
        pass_sensor = 1'b0;
        check("early: door closed", 32'(open_access_door), 32'd0);
        check("early: idle", 32'(state_out), 32'd0);
        check("early: pass_count", 32'(pass_count), 32'd1);
        present(4'd5);
        repeat (16) @(negedge clk);
        check("last: door open cycle 16", 32'(open_access_door), 32'd1);
        pass_sensor = 1'b1;
        @(negedge clk);
        pass_sensor = 1'b0;
        check("last: pass_count", 32'(pass_count), 32'd2);
        check("last: idle", 32'(state_out), 32'd0);

        // Range boundaries
        present(4'd11);
        @(negedge clk);
        check("code 11 accepted", 32'(code_accepted), 32'd1);
        wait_idle();
        present(4'd3);
        @(negedge clk);
        check("code 3 denied", 32'(state_out), 32'd3);
        check("code 3 reject pulse", 32'(code_rejected), 32'd1);
        check("code 3 fail_count", 32'(fail_count), 32'd1);
        @(negedge clk);
        check("denied one cycle", 32'(state_out), 32'd0);
        check("reject pulse ends", 32'(code_rejected), 32'd0);
        present(4'd12);
        @(negedge clk);
        check("code 12 denied", 32'(state_out), 32'd3);
        check("code 12 fail_count", 32'(fail_count), 32'd2);
        @(negedge clk);
        present(4'd4);
        @(negedge clk);
        check("valid clears fail_count", 32'(fail_count), 32'd0);
        wait_idle();
        present(4'd15);
        @(negedge clk);
        check("code 15 denied", 32'(state_out), 32'd3);
        check("code 15 fail_count", 32'(fail_count), 32'd1);
        @(negedge clk);

        // Lockout: 15, 0, 13 consecutive
        present(4'd0);
        repeat (2) @(negedge clk);
        present(4'd13);
        @(negedge clk);
        check("lockout state", 32'(state_out), 32'd4);
        check("lockout flag", 32'(lockout), 32'd1);
        check("lockout reject pulse", 32'(code_rejected), 32'd1);
        check("lockout fail_count", 32'(fail_count), 32'd3);
        n = 1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (lockout) n++;
            validate_code = (i < 40) ? 1'(i % 2) : 1'b0;
            access_code   = 4'd6;
        end
        check("lockout cycles", 32'(n), 32'd64);
        check("after lockout idle", 32'(state_out), 32'd0);
        check("after lockout fail_count", 32'(fail_count), 32'd0);
        present(4'd1);
        repeat (2) @(negedge clk);
        present(4'd14);
        repeat (2) @(negedge clk);
        check("two rejects fail_count", 32'(fail_count), 32'd2);
        present(4'd8);
        @(negedge clk);
        check("inv,inv,valid fail_count", 32'(fail_count), 32'd0);
        check("inv,inv,valid granted", 32'(state_out), 32'd2);
        check("inv,inv,valid no lockout", 32'(lockout), 32'd0);
        wait_idle();

        // Reset in the 8th door cycle acts before any clock edge
        present(4'd6);
        repeat (8) @(negedge clk);
        check("mid-grant door open", 32'(open_access_door), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async reset door", 32'(open_access_door), 32'd0);
        check("async reset state", 32'(state_out), 32'd0);
        check("async reset pass_count", 32'(pass_count), 32'd0);
        check("async reset fail_count", 32'(fail_count), 32'd0);
        check("async reset accept", 32'(code_accepted), 32'd0);
        @(negedge clk);
        rst           = 1'b1;
        access_code   = 4'd9;
        validate_code = 1'b1;
        @(negedge clk);
        validate_code = 1'b0;
        check("first validate after reset", 32'(state_out), 32'd1);
        wait_idle();

        // Passage counting, then wrap from a preloaded count near the top
        for (int i = 0; i < 5; i++) do_pass(4'(CODE_MIN + i));
        check("five passages", 32'(pass_count), 32'd5);
        @(negedge clk);
        #1 force dut.pass_count = 16'hFFFE;
        preload_val = 16'hFFFE;
        preload_req = 1'b1;
        #1 release dut.pass_count;
        @(posedge clk);
        #1 preload_req = 1'b0;
        do_pass(4'd10);
        check("pass_count at FFFF", 32'(pass_count), 32'hFFFF);
        do_pass(4'd9);
        check("pass_count wraps", 32'(pass_count), 32'h0000);
        do_pass(4'd8);
        check("pass_count after wrap", 32'(pass_count), 32'h0001);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
